// File: rtl/operand2_shift_unit_if.sv
// operand2_shift_unit_if
//  Bundles the request and result handshakes of the operand-2 shift unit.
//  Request side : in_valid/in_ready, val_r_m, val_r_s, shift_operand, imm,
//                 is_mem_related, carry_in
//  Result side  : out_valid/out_ready, val_2, shifter_carry_out
//  Status       : busy
//  master = the EXE stage driving requests and consuming results,
//  slave  = the shift unit itself.
interface operand2_shift_unit_if #(
  parameter int DATA_WIDTH        = 32,
  parameter int SHIFT_OPERAND_LEN = 12
);
  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_WIDTH-1:0]        val_r_m;
  logic [DATA_WIDTH-1:0]        val_r_s;
  logic [SHIFT_OPERAND_LEN-1:0] shift_operand;
  logic                         imm;
  logic                         is_mem_related;
  logic                         carry_in;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        val_2;
  logic                         shifter_carry_out;
  logic                         busy;

  modport master (
    output in_valid, val_r_m, val_r_s, shift_operand, imm, is_mem_related,
           carry_in, out_ready,
    input  in_ready, out_valid, val_2, shifter_carry_out, busy
  );

  modport slave (
    input  in_valid, val_r_m, val_r_s, shift_operand, imm, is_mem_related,
           carry_in, out_ready,
    output in_ready, out_valid, val_2, shifter_carry_out, busy
  );
endinterface

// File: rtl/operand2_shift_unit.sv
// operand2_shift_unit
//  Multi-cycle ARM operand-2 generator for the EXE stage. A request is decoded
//  once at accept into (operand, shift kind, clamped amount, initial carry);
//  an iterative shifter then moves at most MAX_STEP bits per cycle until the
//  amount is used up, and the result is held until the consumer takes it.
// Ports
//  clk  - clock, rising edge
//  rst  - asynchronous reset, active-high
//  bus  - operand2_shift_unit_if.slave: request (valid/ready + operands),
//         result (valid/ready + val_2, shifter_carry_out) and busy status
module operand2_shift_unit #(
  parameter int DATA_WIDTH        = 32,
  parameter int MAX_STEP          = 8,
  parameter int SHIFT_OPERAND_LEN = 12
) (
  input logic                 clk,
  input logic                 rst,
  operand2_shift_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef enum logic [2:0] {
    SK_LSL = 3'd0,
    SK_LSR = 3'd1,
    SK_ASR = 3'd2,
    SK_ROR = 3'd3,
    SK_RRX = 3'd4
  } shift_kind_t;

  localparam logic [8:0] DW9   = 9'(DATA_WIDTH);
  localparam logic [8:0] DW9P1 = 9'(DATA_WIDTH + 1);
  localparam logic [8:0] STEP9 = 9'(MAX_STEP);

  state_t                       state_q, state_d;
  shift_kind_t                  kind_q, dec_kind;
  logic [DATA_WIDTH-1:0]        acc_q, dec_acc, sh_acc;
  logic                         carry_q, dec_carry, sh_carry;
  logic [8:0]                   rem_q, dec_rem, dec_n, dec_m, step;
  logic                         accept;
  logic [SHIFT_OPERAND_LEN-1:0] so;
  logic                         unused_rs_high;

  assign so = bus.shift_operand;

  // Only Rs[7:0] carries a shift amount; the upper bits are intentionally ignored.
  assign unused_rs_high = ^bus.val_r_s[DATA_WIDTH-1:8];

  // Decode the request into operand, shift kind, clamped amount and the carry
  // that applies if no bits end up being shifted. Priority: mem > imm > reg > imm-shift.
  always_comb begin
    dec_acc   = bus.val_r_m;
    dec_carry = bus.carry_in;
    dec_kind  = shift_kind_t'({1'b0, so[6:5]});
    dec_rem   = 9'd0;
    dec_n     = 9'd0;
    dec_m     = 9'd0;
    if (bus.is_mem_related) begin
      dec_acc  = DATA_WIDTH'(so);
      dec_kind = SK_LSL;
    end else begin
      if (bus.imm) begin
        dec_acc  = DATA_WIDTH'(so[7:0]);
        dec_kind = SK_ROR;
        dec_n    = {4'b0, so[11:8], 1'b0};
      end else if (so[4]) begin
        dec_n = {1'b0, bus.val_r_s[7:0]};
      end else begin
        dec_n = {4'b0, so[11:7]};
        // Immediate amount 0 encodes LSR/ASR #32 and ROR #0 means RRX.
        if (dec_n == 9'd0) begin
          if (dec_kind == SK_LSR || dec_kind == SK_ASR) dec_n = DW9;
          else if (dec_kind == SK_ROR) dec_kind = SK_RRX;
        end
      end
      dec_m = dec_n % DW9;
      unique case (dec_kind)
        SK_LSL, SK_LSR: dec_rem = (dec_n > DW9) ? DW9P1 : dec_n;
        SK_ASR:         dec_rem = (dec_n > DW9) ? DW9 : dec_n;
        SK_ROR: begin
          dec_rem = dec_m;
          // A full-turn rotation leaves the value intact but still sets C to the MSB.
          if (dec_n != 9'd0 && dec_m == 9'd0) dec_carry = dec_acc[DATA_WIDTH-1];
        end
        default:        dec_rem = 9'd1;
      endcase
    end
  end

  assign step = (rem_q > STEP9) ? STEP9 : rem_q;

  // One SHIFT cycle: apply up to MAX_STEP single-bit shifts; carry tracks the last bit out.
  always_comb begin
    sh_acc   = acc_q;
    sh_carry = carry_q;
    for (int i = 0; i < MAX_STEP; i++) begin
      if (9'(i) < step) begin
        unique case (kind_q)
          SK_LSL: begin
            sh_carry = sh_acc[DATA_WIDTH-1];
            sh_acc   = {sh_acc[DATA_WIDTH-2:0], 1'b0};
          end
          SK_LSR: begin
            sh_carry = sh_acc[0];
            sh_acc   = {1'b0, sh_acc[DATA_WIDTH-1:1]};
          end
          SK_ASR: begin
            sh_carry = sh_acc[0];
            sh_acc   = {sh_acc[DATA_WIDTH-1], sh_acc[DATA_WIDTH-1:1]};
          end
          SK_ROR: begin
            sh_carry = sh_acc[0];
            sh_acc   = {sh_acc[0], sh_acc[DATA_WIDTH-1:1]};
          end
          default: begin
            // RRX always runs a single step, so the stored carry_in is the fill bit.
            sh_carry = sh_acc[0];
            sh_acc   = {carry_q, sh_acc[DATA_WIDTH-1:1]};
          end
        endcase
      end
    end
  end

  // Next-state logic; requests are only looked at while IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = (dec_rem != 9'd0) ? SHIFT : DONE;
        end
      end
      SHIFT:   if (step == rem_q) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Working registers: loaded at accept, advanced in SHIFT, frozen in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      rem_q   <= 9'd0;
      kind_q  <= SK_LSL;
    end else if (accept) begin
      acc_q   <= dec_acc;
      carry_q <= dec_carry;
      rem_q   <= dec_rem;
      kind_q  <= dec_kind;
    end else if (state_q == SHIFT) begin
      acc_q   <= sh_acc;
      carry_q <= sh_carry;
      rem_q   <= rem_q - step;
    end
  end

  assign bus.in_ready          = (state_q == IDLE);
  assign bus.busy              = (state_q != IDLE);
  assign bus.out_valid         = (state_q == DONE);
  assign bus.val_2             = acc_q;
  assign bus.shifter_carry_out = carry_q;

endmodule

// File: tb/tb_operand2_shift_unit.sv
// tb_operand2_shift_unit
//  Directed bench for operand2_shift_unit (DATA_WIDTH=32, MAX_STEP=8).
//  Each request pushes its expected val_2/carry/latency onto a scoreboard
//  queue; the entry is popped and compared when out_valid appears.
module tb_operand2_shift_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  operand2_shift_unit_if #(.DATA_WIDTH(32), .SHIFT_OPERAND_LEN(12)) bus ();

  operand2_shift_unit #(
    .DATA_WIDTH(32),
    .MAX_STEP(8),
    .SHIFT_OPERAND_LEN(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
    logic        carry;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   accept_cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Present one request for exactly one accept edge; optionally record its expectation.
  task automatic applyStimulus(input string tag, input logic [11:0] so,
                               input logic [31:0] rm, input logic [31:0] rs,
                               input logic imm_b, input logic mem_b, input logic cin,
                               input logic push, input logic [31:0] exp_val,
                               input logic exp_c, input int exp_lat);
    exp_t e;
    @(negedge clk);
    checkValue({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.shift_operand  = so;
    bus.val_r_m        = rm;
    bus.val_r_s        = rs;
    bus.imm            = imm_b;
    bus.is_mem_related = mem_b;
    bus.carry_in       = cin;
    bus.in_valid       = 1'b1;
    accept_cyc         = cyc;
    if (push) begin
      e.tag   = tag;
      e.val   = exp_val;
      e.carry = exp_c;
      e.lat   = exp_lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for the result, compare against the oldest expectation,
  // optionally hold out_ready low for 'hold' cycles, then confirm return to IDLE.
  task automatic checkOutput(input int hold);
    exp_t e;
    int   waited;
    e = sb.pop_front();
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkValue({e.tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    checkValue({e.tag, "_latency"}, 32'(cyc - accept_cyc), 32'(e.lat));
    checkValue({e.tag, "_val_2"}, bus.val_2, e.val);
    checkValue({e.tag, "_carry"}, 32'(bus.shifter_carry_out), 32'(e.carry));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      checkValue({e.tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      checkValue({e.tag, "_hold_val_2"}, bus.val_2, e.val);
      checkValue({e.tag, "_hold_carry"}, 32'(bus.shifter_carry_out), 32'(e.carry));
      checkValue({e.tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    if (hold > 0) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    checkValue({e.tag, "_idle_out_valid"}, 32'(bus.out_valid), 32'd0);
    checkValue({e.tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic saw_valid;
    rst                = 1'b1;
    bus.in_valid       = 1'b0;
    bus.val_r_m        = '0;
    bus.val_r_s        = '0;
    bus.shift_operand  = '0;
    bus.imm            = 1'b0;
    bus.is_mem_related = 1'b0;
    bus.carry_in       = 1'b0;
    bus.out_ready      = 1'b1;
    repeat (2) @(negedge clk);

    checkValue("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkValue("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkValue("reset_busy", 32'(bus.busy), 32'd0);
    checkValue("reset_val_2", bus.val_2, 32'd0);
    checkValue("reset_carry", 32'(bus.shifter_carry_out), 32'd0);
    rst = 1'b0;

    applyStimulus("imm_rot8", 12'h4FF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFF000000, 1'b1, 2);
    checkOutput(0);

    applyStimulus("lsl20", 12'hA00, 32'h00000F01, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF0100000, 1'b0, 4);
    checkValue("lsl20_busy", 32'(bus.busy), 32'd1);
    checkOutput(0);

    applyStimulus("asr_reg40", 12'h050, 32'h80000000, 32'd40, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 5);
    checkOutput(0);

    applyStimulus("rrx", 12'h060, 32'h00000003, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000001, 1'b1, 2);
    checkOutput(0);

    applyStimulus("imm_rot0", 12'h0AB, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h000000AB, 1'b1, 1);
    checkOutput(0);

    applyStimulus("lsr_imm0", 12'h020, 32'h80000001, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1, 5);
    checkOutput(0);

    applyStimulus("lsl_reg33", 12'h010, 32'hFFFFFFFF, 32'd33, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000000, 1'b0, 6);
    checkOutput(0);

    applyStimulus("lsl_reg32", 12'h010, 32'h00000001, 32'd32, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1, 5);
    checkOutput(0);

    applyStimulus("ror_reg64", 12'h070, 32'h80000000, 32'd64, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b1, 1);
    checkOutput(0);

    applyStimulus("ror_imm4", 12'h260, 32'h0000000F, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF0000000, 1'b1, 2);
    checkOutput(0);

    applyStimulus("asr_imm3", 12'h1C0, 32'h7FFFFFF8, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0FFFFFFF, 1'b0, 2);
    checkOutput(0);

    applyStimulus("lsr_reg9", 12'h030, 32'hFFFF0000, 32'h00000109, 1'b0, 1'b0, 1'b1, 1'b1, 32'h007FFF80, 1'b0, 3);
    checkOutput(0);

    // mem wins over imm; consumer stalls for three cycles
    bus.out_ready = 1'b0;
    applyStimulus("mem_hold", 12'hABC, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000ABC, 1'b1, 1);
    checkOutput(3);

    // abort a long register shift with an asynchronous reset
    applyStimulus("abort", 12'h010, 32'h00000001, 32'd100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkValue("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkValue("abort_in_ready", 32'(bus.in_ready), 32'd1);
    checkValue("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) saw_valid = 1'b1;
    end
    checkValue("abort_no_result", 32'(saw_valid), 32'd0);
    checkValue("abort_idle_in_ready", 32'(bus.in_ready), 32'd1);

    applyStimulus("lsr_reg0", 12'h030, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b1, 1);
    checkOutput(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
